// File: rtl/spi_pkg.sv
// Shared types for the parametrised SPI master: FSM state encoding and the latched SPI mode.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timebase for the SPI master: counts 0..CLK_DIV-1 while enabled, ticks on the last count.
module spi_clk_div #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Free-running half-period counter; parked at zero whenever disabled so each phase starts aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (!enable) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  assign tick = enable && (cnt_r == LAST);

endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master (width, mode, bit order, chip selects) running entirely on clk;
// sclk is a registered data output, never a clock.
module spi_master_param
  import spi_pkg::*;
#(
  parameter  int DATA_W    = 12,
  parameter  int CLK_DIV   = 10,
  parameter  int NUM_CS    = 1,
  parameter  int LSB_FIRST = 1,
  localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              newd,
  output logic              ready,
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        mode,
  input  logic [CS_W-1:0]   cs_sel,
  output logic              sclk,
  output logic [NUM_CS-1:0] cs_n,
  output logic              mosi,
  input  logic              miso,
  output logic [DATA_W-1:0] dout,
  output logic              done,
  output logic              busy
);

  localparam int HP_W = $clog2(2 * DATA_W + 1);
  localparam logic [HP_W-1:0] LAST_HP = HP_W'(2 * DATA_W - 1);

  spi_state_t        state_r, state_nx;
  spi_mode_t         mode_r;
  logic [HP_W-1:0]   hp_r;
  logic [DATA_W-1:0] tx_r, rx_r, dout_r;
  logic [NUM_CS-1:0] cs_n_r;
  logic              sclk_r, mosi_r, done_r;
  logic              tick_s, accept_s, sample_s, shift_s, finish_s;

  function automatic logic tx_bit(input logic [DATA_W-1:0] w);
    if (LSB_FIRST != 0) return w[0];
    else                return w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] w);
    if (LSB_FIRST != 0) return {1'b0, w[DATA_W-1:1]};
    else                return {w[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] w, input logic b);
    if (LSB_FIRST != 0) return {b, w[DATA_W-1:1]};
    else                return {w[DATA_W-2:0], b};
  endfunction

  // Out-of-range selects match no line, so every chip select stays deasserted
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (CS_W'(i) == sel) v[i] = 1'b0;
    end
    return v;
  endfunction

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk    (clk),
    .rst_n  (rst),
    .enable (state_r != IDLE),
    .tick   (tick_s)
  );

  assign accept_s = (state_r == IDLE) && newd;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_nx;
  end

  // Next state and per-tick strobes; even half-period index is the leading edge of a bit
  always_comb begin
    state_nx = state_r;
    sample_s = 1'b0;
    shift_s  = 1'b0;
    finish_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (newd) state_nx = SETUP;
        else      state_nx = IDLE;
      end
      SETUP: begin
        if (tick_s) state_nx = XFER;
        else        state_nx = SETUP;
      end
      XFER: begin
        if (tick_s) begin
          if (hp_r[0] == 1'b0) begin
            sample_s = ~mode_r.cpha;
            shift_s  = mode_r.cpha;
          end else begin
            sample_s = mode_r.cpha;
            shift_s  = ~mode_r.cpha && (hp_r != LAST_HP);
          end
          if (hp_r == LAST_HP) state_nx = HOLD;
          else                 state_nx = XFER;
        end else begin
          state_nx = XFER;
        end
      end
      HOLD: begin
        if (tick_s) begin
          finish_s = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = HOLD;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: request latch, sclk/mosi/miso shifting, end-of-transfer release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_r <= '0;
      hp_r   <= '0;
      tx_r   <= '0;
      rx_r   <= '0;
      dout_r <= '0;
      cs_n_r <= '1;
      sclk_r <= 1'b0;
      mosi_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= finish_s;
      if (accept_s) begin
        mode_r <= spi_mode_t'(mode);
        sclk_r <= mode[1];
        cs_n_r <= cs_decode(cs_sel);
        hp_r   <= '0;
        rx_r   <= '0;
        if (mode[0] == 1'b0) begin
          mosi_r <= tx_bit(din);
          tx_r   <= tx_shift(din);
        end else begin
          mosi_r <= 1'b0;
          tx_r   <= din;
        end
      end else if ((state_r == XFER) && tick_s) begin
        sclk_r <= ~sclk_r;
        hp_r   <= hp_r + 1'b1;
        if (shift_s) begin
          mosi_r <= tx_bit(tx_r);
          tx_r   <= tx_shift(tx_r);
        end
        if (sample_s) begin
          rx_r <= rx_shift(rx_r, miso);
        end
      end else if (finish_s) begin
        cs_n_r <= '1;
        mosi_r <= 1'b0;
        dout_r <= rx_r;
      end else if (state_r == IDLE) begin
        sclk_r <= mode_r.cpol;
      end
    end
  end

  assign ready = (state_r == IDLE);
  assign busy  = ~ready;
  assign sclk  = sclk_r;
  assign cs_n  = cs_n_r;
  assign mosi  = mosi_r;
  assign dout  = dout_r;
  assign done  = done_r;

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench: two master configurations driven by directed and random requests, checked
// against an edge-counting slave/reference model derived from the SPI framing rules.
module tb_spi_master_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  // A: 12-bit, CLK_DIV 10, 4 selects, LSB first.  B: 8-bit, CLK_DIV 3, 3 selects, MSB first.
  logic        newd_a = 1'b0, miso_a = 1'b0, newd_b = 1'b0, miso_b = 1'b0;
  logic [11:0] din_a = 12'h000;
  logic [7:0]  din_b = 8'h00;
  logic [1:0]  mode_a = 2'b00, mode_b = 2'b00, cs_sel_a = 2'd0, cs_sel_b = 2'd0;
  logic        ready_a, sclk_a, mosi_a, done_a, busy_a;
  logic        ready_b, sclk_b, mosi_b, done_b, busy_b;
  logic [3:0]  cs_n_a;
  logic [2:0]  cs_n_b;
  logic [11:0] dout_a;
  logic [7:0]  dout_b;

  int          checks = 0;
  int          errors = 0;
  logic [11:0] exp_dout_a = 12'h000;
  logic [11:0] exp_dout_b = 12'h000;

  always #5 clk = ~clk;

  spi_master_param #(.DATA_W(12), .CLK_DIV(10), .NUM_CS(4), .LSB_FIRST(1)) u_dut_a (
    .clk(clk), .rst(rst), .newd(newd_a), .ready(ready_a), .din(din_a), .mode(mode_a),
    .cs_sel(cs_sel_a), .sclk(sclk_a), .cs_n(cs_n_a), .mosi(mosi_a), .miso(miso_a),
    .dout(dout_a), .done(done_a), .busy(busy_a)
  );

  spi_master_param #(.DATA_W(8), .CLK_DIV(3), .NUM_CS(3), .LSB_FIRST(0)) u_dut_b (
    .clk(clk), .rst(rst), .newd(newd_b), .ready(ready_b), .din(din_b), .mode(mode_b),
    .cs_sel(cs_sel_b), .sclk(sclk_b), .cs_n(cs_n_b), .mosi(mosi_b), .miso(miso_b),
    .dout(dout_b), .done(done_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic o_sclk(input bit s);   return s ? sclk_b  : sclk_a;  endfunction
  function automatic logic o_mosi(input bit s);   return s ? mosi_b  : mosi_a;  endfunction
  function automatic logic o_done(input bit s);   return s ? done_b  : done_a;  endfunction
  function automatic logic o_ready(input bit s);  return s ? ready_b : ready_a; endfunction
  function automatic logic o_busy(input bit s);   return s ? busy_b  : busy_a;  endfunction
  function automatic logic [3:0] o_cs(input bit s);    return s ? {1'b1, cs_n_b} : cs_n_a; endfunction
  function automatic logic [11:0] o_dout(input bit s); return s ? {4'h0, dout_b} : dout_a; endfunction

  // Reference rules: word width, bit order and chip-select pattern per configuration
  function automatic logic [11:0] wmask(input bit s, input logic [11:0] v);
    return s ? (v & 12'h0FF) : v;
  endfunction

  function automatic logic seq_bit(input bit s, input logic [11:0] v, input int i);
    if (s) return v[7 - i];
    else   return v[i];
  endfunction

  function automatic logic [3:0] exp_cs(input bit s, input logic [1:0] c);
    logic [3:0] r;
    r = 4'hF;
    if (int'(c) < (s ? 3 : 4)) r[c] = 1'b0;
    return r;
  endfunction

  task automatic drive(input bit s, input logic nd, input logic [11:0] d, input logic [1:0] m,
                       input logic [1:0] c);
    if (s) begin newd_b = nd; din_b = d[7:0]; mode_b = m; cs_sel_b = c; end
    else   begin newd_a = nd; din_a = d;      mode_a = m; cs_sel_a = c; end
  endtask

  task automatic set_newd(input bit s, input logic v);
    if (s) newd_b = v; else newd_a = v;
  endtask

  task automatic set_miso(input bit s, input logic v);
    if (s) miso_b = v; else miso_a = v;
  endtask

  // One transfer, called on a falling edge; returns on the falling edge where done is seen
  task automatic xfer(input bit s, input logic [11:0] tx, input logic [1:0] md, input logic [1:0] cs,
                      input logic [11:0] sv, input bit loopback, input bit hold);
    int w, d, nexp, edges, done_at, idx, pos;
    bit tim_ok, cs_ok, busy_ok;
    logic prev;
    logic [11:0] rec, exp_rx, old_dout;
    logic [31:0] rnd;
    w = s ? 8 : 12;
    d = s ? 3 : 10;
    nexp = (2 * w + 2) * d;
    exp_rx = wmask(s, loopback ? tx : sv);
    old_dout = s ? exp_dout_b : exp_dout_a;
    edges = 0; done_at = -1; tim_ok = 1'b1; cs_ok = 1'b1; busy_ok = 1'b1;
    rec = 12'h000; prev = md[1];
    drive(s, 1'b1, tx, md, cs);
    for (int n = 0; n <= nexp + 4; n++) begin
      @(negedge clk);
      if (n == 0) begin
        check("idle_level_after_accept", 32'(o_sclk(s)), 32'(md[1]));
        check("done_one_cycle", 32'(o_done(s)), 32'd0);
        rnd = $urandom;
        drive(s, hold, rnd[11:0], rnd[13:12], rnd[15:14]);
        if (!loopback && md[0] == 1'b0) set_miso(s, seq_bit(s, sv, 0));
      end else if (!hold) begin
        set_newd(s, n == 3 * d);
      end
      if (n == nexp - 1) check("dout_held", 32'(o_dout(s)), 32'(old_dout));
      if (o_sclk(s) !== prev) begin
        prev = o_sclk(s);
        edges++;
        if (n != d * (1 + edges)) tim_ok = 1'b0;
        if (edges <= 2 * w) begin
          if ((edges % 2 == 1) == (md[0] == 1'b0)) begin
            idx = (edges - 1) / 2;
            pos = s ? (w - 1 - idx) : idx;
            rec[pos] = o_mosi(s);
          end else if (!loopback) begin
            idx = md[0] ? (edges - 1) / 2 : edges / 2;
            if (idx < w) set_miso(s, seq_bit(s, sv, idx));
          end
        end
      end
      if (loopback) set_miso(s, o_mosi(s));
      if (o_done(s) === 1'b1) begin
        done_at = n;
        break;
      end
      if (o_cs(s) !== exp_cs(s, cs)) cs_ok = 1'b0;
      if (o_ready(s) !== 1'b0 || o_busy(s) !== 1'b1) busy_ok = 1'b0;
    end
    check("done_cycle", 32'(done_at), 32'(nexp));
    check("sclk_edge_count", 32'(edges), 32'(2 * w));
    check("sclk_edge_timing", 32'(tim_ok), 32'd1);
    check("cs_n_during_xfer", 32'(cs_ok), 32'd1);
    check("busy_during_xfer", 32'(busy_ok), 32'd1);
    check("mosi_bit_order", 32'(rec), 32'(wmask(s, tx)));
    check("dout_received", 32'(o_dout(s)), 32'(exp_rx));
    check("ready_at_done", 32'(o_ready(s)), 32'd1);
    check("busy_at_done", 32'(o_busy(s)), 32'd0);
    check("cs_n_released", 32'(o_cs(s)), 32'hF);
    check("mosi_released", 32'(o_mosi(s)), 32'd0);
    check("sclk_back_at_cpol", 32'(o_sclk(s)), 32'(md[1]));
    if (s) exp_dout_b = exp_rx; else exp_dout_a = exp_rx;
  endtask

  initial begin
    bit ok;
    bit sel;
    logic [31:0] r1, r2;

    repeat (3) @(negedge clk);
    check("rst_ready", 32'({ready_a, ready_b}), 32'd3);
    check("rst_busy", 32'({busy_a, busy_b}), 32'd0);
    check("rst_cs_n", 32'({cs_n_a, cs_n_b}), 32'h7F);
    check("rst_sclk_mosi", 32'({sclk_a, sclk_b, mosi_a, mosi_b}), 32'd0);
    check("rst_dout", 32'({dout_a, dout_b}), 32'd0);
    check("rst_done", 32'({done_a, done_b}), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Mode 0 loopback, LSB first
    xfer(1'b0, 12'hA5C, 2'b00, 2'd0, 12'h000, 1'b1, 1'b0);

    // All four modes against a slave returning 12'h3C1
    for (int m = 0; m < 4; m++) begin
      r1 = $urandom;
      xfer(1'b0, r1[11:0], 2'(m), 2'd1, 12'h3C1, 1'b0, 1'b0);
    end

    // Chip-select decode, including an out-of-range index on the 3-select instance
    r1 = $urandom; r2 = $urandom;
    xfer(1'b0, r1[11:0], r1[13:12], 2'd2, r2[11:0], 1'b0, 1'b0);
    xfer(1'b1, r1[23:12], r1[15:14], 2'd3, r2[23:12], 1'b0, 1'b0);
    xfer(1'b1, r2[11:0], r2[13:12], 2'd2, r1[11:0], 1'b0, 1'b0);

    // newd held high across three back-to-back words
    for (int k = 0; k < 3; k++) begin
      r1 = $urandom; r2 = $urandom;
      xfer(1'b0, r1[11:0], r1[13:12], 2'(k), r2[11:0], 1'b0, 1'b1);
    end
    newd_a = 1'b0;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (ready_a !== 1'b1) ok = 1'b0;
    end
    check("no_accept_after_release", 32'(ok), 32'd1);

    // Reset during the seventh half-period of a mode-2 transfer
    drive(1'b0, 1'b1, 12'hFFF, 2'b10, 2'd1);
    @(negedge clk);
    newd_a = 1'b0;
    repeat (75) @(negedge clk);
    check("pre_reset_sclk", 32'(sclk_a), 32'd1);
    check("pre_reset_cs_n", 32'(cs_n_a), 32'hD);
    check("pre_reset_mosi", 32'(mosi_a), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_cs_n", 32'(cs_n_a), 32'hF);
    check("abort_sclk_mosi", 32'({sclk_a, mosi_a}), 32'd0);
    check("abort_ready_done", 32'({ready_a, done_a}), 32'd2);
    check("abort_dout", 32'(dout_a), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_dout_a = 12'h000;
    exp_dout_b = 12'h000;
    ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done_a !== 1'b0 || dout_a !== 12'h000 || ready_a !== 1'b1 || sclk_a !== 1'b0) ok = 1'b0;
    end
    check("quiet_after_abort", 32'(ok), 32'd1);
    r1 = $urandom;
    xfer(1'b0, r1[11:0], 2'b01, 2'd3, r1[23:12], 1'b0, 1'b0);

    // MSB-first 8-bit word in mode 3
    r1 = $urandom;
    xfer(1'b1, 12'h081, 2'b11, 2'd0, r1[11:0], 1'b0, 1'b0);

    // Random requests on either instance
    for (int k = 0; k < 8; k++) begin
      r1 = $urandom; r2 = $urandom;
      sel = r1[31];
      xfer(sel, r1[11:0], r1[13:12], r1[15:14], r2[11:0], r2[31], 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
